// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_multiplier (+ ripple_carry_adder datapath adder)
// Brief    : Sequential unsigned shift-and-add multiplier with valid/ready
//            handshakes on operands and product. The multiplier consumes one
//            bit per clock and reuses a single BIT_WIDTH-bit ripple adder.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Plain ripple-carry adder. Each carry depends on the previous stage, so this
// carry chain is the multiplier's critical path.
// ----------------------------------------------------------------------------
module ripple_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] w_carry;

    assign w_carry[0] = cin;

    // One full-adder cell per bit, chained through w_carry
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
            assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = w_carry[WIDTH];

endmodule

// ----------------------------------------------------------------------------
// Shift-and-add multiplier. The product register holds the partial sum in its
// upper half and the not-yet-consumed multiplier bits in its lower half; each
// RUN cycle conditionally adds the multiplicand into the upper half (based on
// the LSB) and shifts the whole register right by one.
// ----------------------------------------------------------------------------
module shift_add_multiplier #(
    parameter int BIT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BIT_WIDTH-1:0]   a,
    input  logic [BIT_WIDTH-1:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*BIT_WIDTH-1:0] p
);

    localparam int c_cnt_w = $clog2(BIT_WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(BIT_WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]             r_state;
    logic [BIT_WIDTH-1:0]   r_mcand;
    logic [2*BIT_WIDTH-1:0] r_prod;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_in_ready;
    logic                   r_out_valid;

    logic [BIT_WIDTH-1:0]   w_hi;
    logic [BIT_WIDTH-1:0]   w_sum;
    logic                   w_cout;
    logic [2*BIT_WIDTH-1:0] w_prod_next;

    assign w_hi = r_prod[2*BIT_WIDTH-1:BIT_WIDTH];

    ripple_carry_adder #(
        .WIDTH (BIT_WIDTH)
    ) u_adder (
        .a    (w_hi),
        .b    (r_mcand),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Pre-shift value is {cout, sum, lo} or {0, hi, lo}; the right shift drops
    // lo[0], so the carry-out lands in the product MSB and nothing overflows.
    assign w_prod_next = r_prod[0] ? {w_cout, w_sum, r_prod[BIT_WIDTH-1:1]}
                                   : {1'b0, r_prod[2*BIT_WIDTH-1:1]};

    // Control FSM and datapath registers; handshake outputs are registered so
    // neither ready nor valid depends combinationally on the opposite input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_mcand     <= '0;
            r_prod      <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_mcand    <= a;
                        r_prod     <= {{BIT_WIDTH{1'b0}}, b};
                        r_cnt      <= '0;
                        r_state    <= c_st_run;
                        r_in_ready <= 1'b0;
                    end
                end
                c_st_run: begin
                    r_prod <= w_prod_next;
                    r_cnt  <= r_cnt + c_cnt_one;
                    if (r_cnt == c_last_iter) begin
                        r_state     <= c_st_done;
                        r_out_valid <= 1'b1;
                    end
                end
                c_st_done: begin
                    // Product is held (not cleared) until the consumer takes it
                    if (out_ready) begin
                        r_state     <= c_st_idle;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign p         = r_prod;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_add_multiplier
// Brief    : Self-checking bench for shift_add_multiplier; expected products
//            come from plain a*b arithmetic and a FIFO scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_shift_add_multiplier;

    localparam int W     = 8;
    localparam int N_B2B = 1000;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] p;

    int n_vec;
    int n_err;

    shift_add_multiplier #(
        .BIT_WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges outside a bounded wait
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present operands at a falling edge and hold them until accepted.
    // Returns at the falling edge right after the acceptance edge.
    task automatic apply_operands(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  output bit ok);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        ok       = in_ready;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count clock edges after acceptance until out_valid is seen (bounded)
    task automatic wait_out_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        bit ok;
        int lat;
        // Reset held from time zero: idle outputs
        #13;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_vec++; if (p !== '0) begin n_err++; $display("FAIL reset_p got=%0d want=0", p); end
        @(negedge clk);
        rst = 1'b0;
        // Park a product in DONE, then reset asynchronously between edges
        out_ready = 1'b0;
        apply_operands(8'd77, 8'd91, ok);
        wait_out_valid(lat);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL async_reset_in_ready got=%b want=1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_reset_out_valid got=%b want=0", out_valid); end
        n_vec++; if (p !== '0) begin n_err++; $display("FAIL async_reset_p got=%0d want=0", p); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit ok;
        int lat;
        out_ready = 1'b1;
        apply_operands(8'd13, 8'd11, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL basic_accept got=in_ready low want=accepted"); end
        wait_out_valid(lat);
        n_vec++; if (lat != W) begin n_err++; $display("FAIL basic_latency got=%0d want=%0d", lat, W); end
        n_vec++; if (p !== 16'd143) begin n_err++; $display("FAIL basic_product got=%0d want=143", p); end
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready_after got=%b want=1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_out_valid_after got=%b want=0", out_valid); end
    endtask

    task automatic test_corners();
        int ta [5] = '{0, 255, 1, 255, 128};
        int tb [5] = '{0, 1, 255, 255, 2};
        bit ok;
        int lat;
        logic [2*W-1:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp = (2*W)'(ta[i] * tb[i]);
            apply_operands(W'(ta[i]), W'(tb[i]), ok);
            wait_out_valid(lat);
            n_vec++; if (lat != W) begin n_err++; $display("FAIL corner_latency %0d*%0d got=%0d want=%0d", ta[i], tb[i], lat, W); end
            n_vec++; if (p !== exp) begin n_err++; $display("FAIL corner_product %0d*%0d got=%0d want=%0d", ta[i], tb[i], p, exp); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure_busy();
        bit ok;
        int lat;
        logic [2*W-1:0] exp;
        exp = (2*W)'(255 * 15);
        out_ready = 1'b0;
        apply_operands(8'hFF, 8'h0F, ok);
        // Foreign operands offered throughout RUN and DONE must be ignored
        a        = 8'd5;
        b        = 8'd9;
        in_valid = 1'b1;
        wait_out_valid(lat);
        n_vec++; if (lat != W) begin n_err++; $display("FAIL bp_latency got=%0d want=%0d", lat, W); end
        n_vec++; if (p !== exp) begin n_err++; $display("FAIL bp_product got=%0d want=%0d", p, exp); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid cyc=%0d got=%b want=1", i, out_valid); end
            n_vec++; if (p !== exp) begin n_err++; $display("FAIL bp_hold_p cyc=%0d got=%0d want=%0d", i, p, exp); end
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL busy_in_ready cyc=%0d got=%b want=0", i, in_ready); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready got=%b want=1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_err++; $display("FAIL busy_not_accepted cyc=%0d got valid=%b ready=%b want valid=0 ready=1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int lat;
        out_ready = 1'b1;
        apply_operands(8'd200, 8'd200, ok);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || p !== '0) begin
            n_err++; $display("FAIL midrst_outputs got valid=%b ready=%b p=%0d want 0/1/0", out_valid, in_ready, p);
        end
        @(negedge clk);
        rst = 1'b0;
        apply_operands(8'd3, 8'd7, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL midrst_accept got=in_ready low want=accepted"); end
        wait_out_valid(lat);
        n_vec++; if (lat != W) begin n_err++; $display("FAIL midrst_latency got=%0d want=%0d", lat, W); end
        n_vec++; if (p !== 16'd21) begin n_err++; $display("FAIL midrst_product got=%0d want=21", p); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] sb [$];
        int sent;
        int got;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sent = 0;
        got  = 0;
        fork
            begin : producer
                bit pending;
                int cyc;
                pending = 1'b0;
                cyc     = 0;
                while (sent < N_B2B && cyc < 40000) begin
                    @(negedge clk);
                    cyc++;
                    if (pending) begin
                        in_valid = 1'b0;
                        pending  = 1'b0;
                    end
                    if (!in_valid && $urandom_range(0, 3) != 0) begin
                        a        = W'($urandom);
                        b        = W'($urandom);
                        in_valid = 1'b1;
                    end
                    // Acceptance happens on the coming rising edge
                    if (in_valid && in_ready) begin
                        sb.push_back((2*W)'(int'(a) * int'(b)));
                        sent++;
                        pending = 1'b1;
                    end
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin : consumer
                int cyc;
                logic [2*W-1:0] exp;
                cyc = 0;
                while (got < N_B2B && cyc < 40000) begin
                    @(negedge clk);
                    cyc++;
                    out_ready = ($urandom_range(0, 1) == 1);
                    if (out_valid && out_ready) begin
                        n_vec++;
                        if (sb.size() == 0) begin
                            n_err++; $display("FAIL b2b_unexpected got=%0d want=no product", p);
                        end else begin
                            exp = sb.pop_front();
                            if (p !== exp) begin
                                n_err++; $display("FAIL b2b_product idx=%0d got=%0d want=%0d", got, p, exp);
                            end
                        end
                        got++;
                    end
                end
            end
        join
        @(negedge clk);
        out_ready = 1'b0;
        n_vec++; if (got != N_B2B) begin n_err++; $display("FAIL b2b_count got=%0d want=%0d", got, N_B2B); end
        n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL b2b_leftover got=%0d want=0", sb.size()); end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        test_reset();
        test_basic();
        test_corners();
        test_backpressure_busy();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
